// File: rtl/spm_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spm_arbiter_pkg
// Description : Shared base-core definitions for the scratch-pad memory
//               arbiter: word address/data bus widths and the 2-bit access
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package spm_arbiter_pkg;

    // Word address and word data bus widths of the base core
    localparam int c_WORD_ADDR_W = 30;
    localparam int c_WORD_DATA_W = 32;

    // Access state: which requester (if any) owns the SPM response cycle
    typedef enum logic [1:0] {
        SPM_ARB_IDLE    = 2'd0,
        SPM_ARB_IF_ACC  = 2'd1,
        SPM_ARB_MEM_ACC = 2'd2
    } spm_arb_state_e;

endpackage : spm_arbiter_pkg
`default_nettype wire

// File: rtl/spm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spm_arbiter
// Description : Arbitrates the single-port scratch-pad memory between the
//               instruction-fetch (read-only) bus and the MEM-stage bus.
//               One grant per cycle, MEM preferred, with an anti-starvation
//               counter that forces an IF win. Fixed one-cycle latency: the
//               grant cycle drives the SPM, the following cycle returns rdy.
// Revision    : 1.0 - initial release
// ============================================================================
module spm_arbiter
    import spm_arbiter_pkg::*;
#(
    parameter int ADDR_W     = c_WORD_ADDR_W,
    parameter int DATA_W     = c_WORD_DATA_W,
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = 2
) (
    input  logic              clk,
    input  logic              reset,
    // IF bus (read only)
    input  logic              if_as_,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rdy,
    output logic [DATA_W-1:0] if_rd_data,
    // MEM-stage bus
    input  logic              mem_as_,
    input  logic              mem_rw,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_rdy,
    output logic [DATA_W-1:0] mem_rd_data,
    // SPM port
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [ADDR_W-1:0] spm_addr,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] spm_rd_data
);

    localparam logic [CNT_W-1:0] c_STARVE_LIMIT = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] c_CNT_SAT      = {CNT_W{1'b1}};

    spm_arb_state_e   state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             mem_rw_q, mem_rw_d;

    logic             w_if_elig;
    logic             w_mem_elig;
    spm_arb_state_e   w_grant;

    // Grant selection, SPM bus drive and next-state / starvation update
    always_comb begin
        // A requester is not eligible in its own rdy cycle
        w_if_elig  = !if_as_  && (state_q != SPM_ARB_IF_ACC);
        w_mem_elig = !mem_as_ && (state_q != SPM_ARB_MEM_ACC);

        // Reset suppresses any grant so the SPM sees no stray strobe
        w_grant = SPM_ARB_IDLE;
        if (!reset) begin
            if (w_if_elig && (!w_mem_elig || (starve_q == c_STARVE_LIMIT))) begin
                w_grant = SPM_ARB_IF_ACC;
            end else if (w_mem_elig) begin
                w_grant = SPM_ARB_MEM_ACC;
            end
        end

        spm_as_     = 1'b1;
        spm_rw      = 1'b0;
        spm_addr    = '0;
        spm_wr_data = '0;
        case (w_grant)
            SPM_ARB_IF_ACC: begin
                spm_as_  = 1'b0;
                spm_addr = if_addr;
            end
            SPM_ARB_MEM_ACC: begin
                spm_as_     = 1'b0;
                spm_rw      = mem_rw;
                spm_addr    = mem_addr;
                spm_wr_data = mem_wr_data;
            end
            default: ;
        endcase

        state_d = w_grant;

        // Count consecutive IF denials; an idle IF or an IF win clears it
        starve_d = starve_q;
        if (if_as_ || (w_grant == SPM_ARB_IF_ACC)) begin
            starve_d = '0;
        end else if (w_if_elig && (starve_q != c_CNT_SAT)) begin
            starve_d = starve_q + 1'b1;
        end

        // Direction is captured at grant so the rdy cycle knows read vs write
        mem_rw_d = (w_grant == SPM_ARB_MEM_ACC) ? mem_rw : mem_rw_q;
    end

    // State, starvation counter and latched MEM direction
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SPM_ARB_IDLE;
            starve_q <= '0;
            mem_rw_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            mem_rw_q <= mem_rw_d;
        end
    end

    // Response side: rdy and read data follow the access state; reset kills a pending rdy
    always_comb begin
        if_rdy      = 1'b0;
        if_rd_data  = '0;
        mem_rdy     = 1'b0;
        mem_rd_data = '0;
        if (!reset) begin
            case (state_q)
                SPM_ARB_IF_ACC: begin
                    if_rdy     = 1'b1;
                    if_rd_data = spm_rd_data;
                end
                SPM_ARB_MEM_ACC: begin
                    mem_rdy     = 1'b1;
                    mem_rd_data = mem_rw_q ? '0 : spm_rd_data;
                end
                default: ;
            endcase
        end
    end

endmodule : spm_arbiter
`default_nettype wire
